// File: rtl/vector_lambert_shade.sv
// Lambert shading: clamp(dot(normal, light)) with a one-stage operand register
// and a 4-entry result FIFO. Vectors are packed {x, y, z} fixed-point words.

module vector_dot_product #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12
) (
    input  logic [3*DATA_W-1:0]      i_op1,
    input  logic [3*DATA_W-1:0]      i_op2,
    output logic signed [DATA_W-1:0] o_dot,
    output logic                     o_overflow
);
    localparam int PW = 2 * DATA_W;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] MAX_V = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

    logic signed [PW-1:0] w_prod [3];
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_shift;

    for (genvar g = 0; g < 3; g++) begin : g_mul
        logic signed [DATA_W-1:0] w_a;
        logic signed [DATA_W-1:0] w_b;
        assign w_a       = i_op1[(2-g)*DATA_W +: DATA_W];
        assign w_b       = i_op2[(2-g)*DATA_W +: DATA_W];
        assign w_prod[g] = PW'(w_a) * PW'(w_b);
    end

    // Full-precision sum, then drop the fraction bits of the product (floor).
    assign w_sum      = SW'(w_prod[0]) + SW'(w_prod[1]) + SW'(w_prod[2]);
    assign w_shift    = w_sum >>> FRAC_W;
    assign o_overflow = (w_shift > MAX_V) || (w_shift < MIN_V);
    assign o_dot      = w_shift[DATA_W-1:0];
endmodule

module vector_lambert_shade #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     light_we,
    input  logic [3*DATA_W-1:0]      light_dir,
    input  logic                     in_valid,
    input  logic [3*DATA_W-1:0]      in_normal,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_intensity,
    output logic                     out_clamped,
    input  logic                     out_ready
);
    localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

    logic [3*DATA_W-1:0]      r_light;
    logic [3*DATA_W-1:0]      r_normal_p1;
    logic [3*DATA_W-1:0]      r_light_p1;
    logic                     r_vld_p1;
    logic [DATA_W:0]          r_fifo_mem [4];
    logic [1:0]               r_wr_ptr;
    logic [1:0]               r_rd_ptr;
    logic [2:0]               r_count;

    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic signed [DATA_W-1:0] w_dot;
    logic                     w_ovf;
    logic [DATA_W:0]          w_shade;
    logic [DATA_W:0]          w_head;

    // Returns {clamped, intensity}; overflow wins over the sign test.
    function automatic logic [DATA_W:0] lambert_clamp(
        input logic signed [DATA_W-1:0] dot,
        input logic                     ovf
    );
        if (ovf)
            return {1'b1, ONE};
        else if (dot < 0)
            return {1'b1, {DATA_W{1'b0}}};
        else if (dot > ONE)
            return {1'b1, ONE};
        else
            return {1'b0, dot};
    endfunction

    // No pop lookahead: a sample sitting in S1 always has a free FIFO slot.
    assign in_ready = (4'(r_count) + 4'(r_vld_p1)) < 4'd4;
    assign w_accept = in_valid & in_ready;
    assign out_valid = (r_count != 3'd0);
    assign w_pop    = out_valid & out_ready;
    assign w_push   = r_vld_p1;

    // ---- stage p0 -> p1: capture operands with the light seen at acceptance
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_normal_p1 <= in_normal;
            r_light_p1  <= r_light;
        end
    end

    vector_dot_product #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_dot (
        .i_op1      (r_normal_p1),
        .i_op2      (r_light_p1),
        .o_dot      (w_dot),
        .o_overflow (w_ovf)
    );

    assign w_shade = lambert_clamp(w_dot, w_ovf);

    // ---- stage p1 -> FIFO: clamped result enters the queue
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo_mem[r_wr_ptr] <= w_shade;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_light  <= '0;
            r_vld_p1 <= 1'b0;
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (light_we)
                r_light <= light_dir;
            r_vld_p1 <= w_accept;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head        = r_fifo_mem[r_rd_ptr];
    assign out_intensity = out_valid ? w_head[DATA_W-1:0] : '0;
    assign out_clamped   = out_valid ? w_head[DATA_W]     : 1'b0;
endmodule

// File: tb/tb_vector_lambert_shade.sv
// Directed checks of vector_lambert_shade: clamp cases, latency, backpressure,
// light update timing, reset flush and streaming throughput.

module tb_vector_lambert_shade;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;
    localparam int ONE    = 1 << FRAC_W;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     light_we;
    logic [3*DATA_W-1:0]      light_dir;
    logic                     in_valid;
    logic [3*DATA_W-1:0]      in_normal;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_intensity;
    logic                     out_clamped;
    logic                     out_ready;

    int checks = 0;
    int errors = 0;

    vector_lambert_shade #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .light_we      (light_we),
        .light_dir     (light_dir),
        .in_valid      (in_valid),
        .in_normal     (in_normal),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_intensity (out_intensity),
        .out_clamped   (out_clamped),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [3*DATA_W-1:0] vec(input int x, input int y, input int z);
        return {x[DATA_W-1:0], y[DATA_W-1:0], z[DATA_W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Load a light, accept one normal, verify 2-cycle latency and the result.
    task automatic single(input string tag, input logic [3*DATA_W-1:0] l,
                          input logic [3*DATA_W-1:0] n, input int exp_i, input int exp_c);
        light_we = 1'b1; light_dir = l; in_valid = 1'b0; out_ready = 1'b0;
        step();
        light_we = 1'b0; in_valid = 1'b1; in_normal = n;
        step();
        in_valid = 1'b0;
        check({tag, "_s1_only"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_int"}, 32'(out_intensity), 32'(exp_i));
        check({tag, "_clamp"}, 32'(out_clamped), 32'(exp_c));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int acc;
        rst_n = 1'b0; light_we = 1'b0; light_dir = '0;
        in_valid = 1'b0; in_normal = '0; out_ready = 1'b0;
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_int", 32'(out_intensity), 32'd0);
        check("rst_clamp", 32'(out_clamped), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        single("aligned", vec(ONE, 0, 0), vec(ONE, 0, 0), ONE, 0);
        single("opposite", vec(ONE, 0, 0), vec(-ONE, 0, 0), 0, 1);
        single("half", vec(ONE, 0, 0), vec(ONE/2, 0, 0), ONE/2, 0);
        single("above_one", vec(ONE, 0, 0), vec(2*ONE, 0, 0), ONE, 1);
        single("ovf_pos", vec(7*ONE, 0, 0), vec(7*ONE, 0, 0), ONE, 1);
        single("ovf_neg", vec(7*ONE, 0, 0), vec(-7*ONE, 0, 0), ONE, 1);
        single("two_axis", vec(ONE/2, ONE/2, 0), vec(ONE, ONE, 0), ONE, 0);
        single("z_neg", vec(0, 0, ONE), vec(ONE/4, ONE, -ONE/4), 0, 1);
        single("z_pos", vec(0, 0, ONE), vec(0, 0, 3*ONE/4), 3*ONE/4, 0);

        // Backpressure: FIFO holds 4, S1 must not be refilled beyond that.
        light_we = 1'b1; light_dir = vec(ONE, 0, 0);
        step();
        light_we = 1'b0; out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            logic took;
            in_valid  = 1'b1;
            in_normal = vec((ONE/8) * (acc + 1), 0, 0);
            took = in_ready;
            step();
            if (took) begin
                acc++;
                if (acc == 4)
                    check("bp_ready_low_after_4th", 32'(in_ready), 32'd0);
            end
        end
        in_valid = 1'b0;
        check("bp_accepts", 32'(acc), 32'd4);
        check("bp_ready_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_order", 32'(out_intensity), 32'((ONE/8) * (i + 1)));
            check("bp_clamp", 32'(out_clamped), 32'd0);
            step();
            if (i == 0)
                check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        end
        check("bp_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Light write in the accept cycle only affects later accepts.
        out_ready = 1'b1;
        light_we = 1'b1; light_dir = vec(0, ONE, 0);
        in_valid = 1'b1; in_normal = vec(ONE, 0, 0);
        step();
        light_we = 1'b0; in_normal = vec(0, ONE, 0);
        step();
        in_valid = 1'b0;
        check("lw_first_valid", 32'(out_valid), 32'd1);
        check("lw_first_old_light", 32'(out_intensity), 32'(ONE));
        step();
        check("lw_second_valid", 32'(out_valid), 32'd1);
        check("lw_second_new_light", 32'(out_intensity), 32'(ONE));
        step();
        check("lw_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset with S1 valid and three entries queued.
        light_we = 1'b1; light_dir = vec(ONE, 0, 0);
        step();
        light_we = 1'b0; in_valid = 1'b1; in_normal = vec(ONE, 0, 0);
        repeat (4) step();
        check("rr_pre_count3", 32'(in_ready), 32'd0);
        rst_n = 1'b0; light_we = 1'b1; light_dir = vec(ONE, 0, 0);
        step();
        rst_n = 1'b1; light_we = 1'b0; in_valid = 1'b0;
        check("rr_out_valid", 32'(out_valid), 32'd0);
        check("rr_in_ready", 32'(in_ready), 32'd1);
        check("rr_int", 32'(out_intensity), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rr_no_stale", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1; in_normal = vec(ONE, 0, 0);
        step();
        in_valid = 1'b0;
        step();
        check("rr_zero_light_valid", 32'(out_valid), 32'd1);
        check("rr_zero_light_int", 32'(out_intensity), 32'd0);
        check("rr_zero_light_clamp", 32'(out_clamped), 32'd0);
        step();

        // Streaming: one result per cycle, FIFO never backs up.
        light_we = 1'b1; light_dir = vec(ONE, 0, 0);
        step();
        light_we = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid  = (c < 8);
            in_normal = vec(256 * (c + 1), 0, 0);
            step();
            check("st_in_ready", 32'(in_ready), 32'd1);
            if (c >= 1 && c <= 8) begin
                check("st_valid", 32'(out_valid), 32'd1);
                check("st_int", 32'(out_intensity), 32'(256 * c));
            end else begin
                check("st_idle", 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_lambert_shade.md
VECTOR_LAMBERT_SHADE -- requirements
Module: vector_lambert_shade

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL: rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-003 SHALL: light_we  input  1  load light_dir into the light register.
REQ-004 SHALL: light_dir  input  vector::vector_t  unit light direction (fixed_point components).
REQ-005 SHALL: in_valid  input  1  in_normal carries a normalized vector (vector_normalize result, caller-aligned).
REQ-006 SHALL: in_normal  input  vector::vector_t  surface normal.
REQ-007 SHALL: in_ready  output  1  block accepts in_normal this cycle.
REQ-008 SHALL: out_valid  output  1  FIFO head valid.
REQ-009 SHALL: out_intensity  output  fixed_point::fixed_point_t  clamped Lambert term, range [0, one], one = 1 << `FIXED_FRACTION_W.
REQ-010 SHALL: out_clamped  output  1  head result was clamped.
REQ-011 SHALL: out_ready  input  1  consumer takes head this cycle.

Function
REQ-012 SHALL: accept = in_valid & in_ready; on accept, stage S1 captures in_normal, the current light register and s1_valid=1; otherwise s1_valid<=0.
REQ-013 SHALL: light register update on light_we takes effect for accepts from the next edge; samples already in S1/FIFO keep the light captured at acceptance.
REQ-014 SHALL: S1 drives one vector_dot_product instance (op1 = S1 normal, op2 = S1 light); its result is clamped and pushed to the FIFO on the next edge when s1_valid=1.
REQ-015 SHALL: clamp rules, in priority order: overflow -> one, clamped=1; dot < 0 (signed) -> 0, clamped=1; dot > one -> one, clamped=1; else dot, clamped=0.
REQ-016 SHALL: latency: accept at edge k -> out_valid=1 after edge k+1 when FIFO empty (2-cycle).
REQ-017 SHALL: FIFO is 4 entries {intensity, clamped}, circular 2-bit read/write pointers, 3-bit count 0..4, wrap from 3 to 0.
REQ-018 SHALL: out_valid = (count != 0); pop on out_valid & out_ready.
REQ-019 SHALL: out_intensity and out_clamped = 0 when out_valid=0.
REQ-020 SHALL: in_ready = (count + s1_valid) < 4, computed from registers only (no same-cycle pop lookahead); S1 push can therefore never overflow the FIFO.
REQ-021 SHALL: simultaneous push and pop leaves count unchanged and preserves order; pop with count=0 ignored.
REQ-022 SHALL: throughput one result per cycle with out_ready held high.
REQ-023 SHALL: output ordering equals acceptance ordering.

Reset
REQ-024 SHALL: while rst_n=0 at an edge: light register <= 0, s1_valid <= 0, count <= 0, pointers <= 0; light_we and in_valid ignored.
REQ-025 SHALL: outputs after reset: out_valid=0, out_intensity=0, out_clamped=0, in_ready=1.
REQ-026 SHALL: reset mid-operation discards S1 and all FIFO entries with no output pulse.

Verification
REQ-027 SHALL: light=(one,0,0), normal=(one,0,0) accepted at edge k -> out_valid after edge k+1, out_intensity=one, out_clamped=0.
REQ-028 SHALL: light=(one,0,0), normal=(-one,0,0) -> out_intensity=0, out_clamped=1; normal=(one/2,0,0) -> one/2, clamped=0.
REQ-029 SHALL: out_ready=0, in_valid=1 for 6 cycles -> exactly 4 accepts, in_ready=0 after 4th accept; then out_ready=1 -> 4 results in order, in_ready returns 1 the cycle after the first pop.
REQ-030 SHALL: light_we changes light to (0,one,0) in the same cycle as accept of normal (one,0,0), next accept normal (0,one,0) -> results one then one; sample accepted in the light_we cycle uses old light.
REQ-031 SHALL: rst_n=0 for one edge with S1 valid and count=3 -> out_valid=0, in_ready=1, no stale result emitted afterward, light reads 0 (next normal gives 0, clamped=0).
REQ-032 SHALL: out_ready=1 continuous, 8 back-to-back accepts -> 8 consecutive out_valid cycles, count never exceeds 1.
